// File: rtl/uart_receiver.sv
// UART receive stage: 16x oversampled start/data/parity/stop validation,
// packing 5-8 bit characters LSB-first into one DATA_WIDTH word.
module uart_receiver #(
   parameter int DATA_WIDTH = 32,
   parameter int OVERSAMPLE = 16
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  rx_tick,
   input  logic                  rx_enable,
   input  logic                  Rx,
   input  logic [3:0]            frame_length,
   input  logic [1:0]            parity_signal,
   input  logic                  stop_bits,
   output logic [DATA_WIDTH-1:0] RX_data,
   output logic                  RX_done,
   output logic                  parity_error,
   output logic                  frame_error
);

   localparam int         IW        = $clog2(DATA_WIDTH);
   localparam logic [5:0] WORD_BITS = 6'(DATA_WIDTH);
   localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
   localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP1, STOP2, CHECK
   } state_t;

   state_t                state, state_n;
   logic                  rx_meta, rx_s;
   logic [3:0]            tcnt, tcnt_n;
   logic [2:0]            dcnt, dcnt_n;
   logic [5:0]            widx, widx_n;
   logic [DATA_WIDTH-1:0] word_reg, word_reg_n;
   logic                  par_acc, par_acc_n;
   logic                  par_err_acc, par_err_acc_n;
   logic                  frm_err_acc, frm_err_acc_n;
   logic                  armed, armed_n;
   logic [DATA_WIDTH-1:0] data_n;
   logic                  done_n, perr_n, ferr_n;
   logic [3:0]            fl_eff;
   logic [2:0]            last_dcnt;
   logic                  exp_par;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= Rx;
         rx_s    <= rx_meta;
      end
   end

   always_comb begin
      if (frame_length >= 4'd5 && frame_length <= 4'd8) fl_eff = frame_length;
      else                                              fl_eff = 4'd8;
      last_dcnt = 3'(fl_eff - 4'd1);
      exp_par   = parity_signal[0] ? par_acc : ~par_acc;
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state        <= IDLE;
         tcnt         <= '0;
         dcnt         <= '0;
         widx         <= '0;
         word_reg     <= '0;
         par_acc      <= 1'b0;
         par_err_acc  <= 1'b0;
         frm_err_acc  <= 1'b0;
         armed        <= 1'b1;
         RX_data      <= '0;
         RX_done      <= 1'b0;
         parity_error <= 1'b0;
         frame_error  <= 1'b0;
      end else begin
         state        <= state_n;
         tcnt         <= tcnt_n;
         dcnt         <= dcnt_n;
         widx         <= widx_n;
         word_reg     <= word_reg_n;
         par_acc      <= par_acc_n;
         par_err_acc  <= par_err_acc_n;
         frm_err_acc  <= frm_err_acc_n;
         armed        <= armed_n;
         RX_data      <= data_n;
         RX_done      <= done_n;
         parity_error <= perr_n;
         frame_error  <= ferr_n;
      end
   end

   always_comb begin
      state_n       = state;
      tcnt_n        = tcnt;
      dcnt_n        = dcnt;
      widx_n        = widx;
      word_reg_n    = word_reg;
      par_acc_n     = par_acc;
      par_err_acc_n = par_err_acc;
      frm_err_acc_n = frm_err_acc;
      armed_n       = armed;
      data_n        = RX_data;
      done_n        = 1'b0;
      perr_n        = parity_error;
      ferr_n        = frame_error;

      if (!rx_enable) begin
         state_n       = IDLE;
         tcnt_n        = '0;
         dcnt_n        = '0;
         widx_n        = '0;
         word_reg_n    = '0;
         par_acc_n     = 1'b0;
         par_err_acc_n = 1'b0;
         frm_err_acc_n = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               tcnt_n = '0;
               // after a zero stop bit the line must return high before re-arming
               if (rx_tick) begin
                  if (rx_s)       armed_n = 1'b1;
                  else if (armed) state_n = START;
               end
            end
            START: begin
               if (rx_tick) begin
                  if (tcnt == MID_TICK) begin
                     tcnt_n  = '0;
                     state_n = rx_s ? IDLE : DATA;
                  end else begin
                     tcnt_n = tcnt + 4'd1;
                  end
               end
            end
            DATA: begin
               if (rx_tick) begin
                  tcnt_n = tcnt + 4'd1;
                  if (tcnt == LAST_TICK) begin
                     if (widx < WORD_BITS) word_reg_n[widx[IW-1:0]] = rx_s;
                     widx_n    = widx + 6'd1;
                     dcnt_n    = dcnt + 3'd1;
                     par_acc_n = par_acc ^ rx_s;
                     if (dcnt == last_dcnt) state_n = parity_signal[1] ? PARITY : STOP1;
                  end
               end
            end
            PARITY: begin
               if (rx_tick) begin
                  tcnt_n = tcnt + 4'd1;
                  if (tcnt == LAST_TICK) begin
                     if (rx_s != exp_par) par_err_acc_n = 1'b1;
                     state_n = STOP1;
                  end
               end
            end
            STOP1, STOP2: begin
               if (rx_tick) begin
                  tcnt_n = tcnt + 4'd1;
                  if (tcnt == LAST_TICK) begin
                     if (!rx_s) begin
                        frm_err_acc_n = 1'b1;
                        armed_n       = 1'b0;
                     end
                     state_n = (state == STOP1 && stop_bits) ? STOP2 : CHECK;
                  end
               end
            end
            CHECK: begin
               if (widx >= WORD_BITS) begin
                  data_n        = word_reg;
                  perr_n        = par_err_acc;
                  ferr_n        = frm_err_acc;
                  done_n        = 1'b1;
                  widx_n        = '0;
                  word_reg_n    = '0;
                  par_err_acc_n = 1'b0;
                  frm_err_acc_n = 1'b0;
               end
               dcnt_n    = '0;
               par_acc_n = 1'b0;
               state_n   = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

endmodule
